// File: rtl/rt_delay_detect.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// rt_delay_detect
//
// Measures the latency between a reference stream and a delayed copy of it.
// After a start request the block refills its ref_in history, then tries
// candidate delays 0..MAXD in order. A candidate is accepted after WINDOW
// consecutive matching samples. While locked, the accepted delay is re-checked
// on every qualified sample. If it breaks, the search restarts from 0.
//
// Ports
//   clk     : single clock, rising edge
//   rst_n   : asynchronous active-low reset
//   en      : sample qualifier; all state holds while low
//   start   : single-cycle begin/restart request (ignored while en is low)
//   ref_in  : undelayed reference samples            [DATA_WIDTH]
//   dly_in  : delayed copy of the reference          [DATA_WIDTH]
//   delay   : current candidate / detected delay     [DELAY_WIDTH]
//   locked  : delay is valid and still matching
//   fail    : no candidate 0..MAXD produced a lock
//   busy    : refilling history or searching
// -----------------------------------------------------------------------------
module rt_delay_detect #(
  parameter int DATA_WIDTH  = 8,
  parameter int DELAY_WIDTH = 5,
  parameter int WINDOW      = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   start,
  input  logic [DATA_WIDTH-1:0]  ref_in,
  input  logic [DATA_WIDTH-1:0]  dly_in,
  output logic [DELAY_WIDTH-1:0] delay,
  output logic                   locked,
  output logic                   fail,
  output logic                   busy
);

  localparam int MAXD  = (1 << DELAY_WIDTH) - 1;
  localparam int NTAPS = MAXD + 1;
  // Wide enough to hold WINDOW itself, so the match count never wraps.
  localparam int CNT_W = $clog2(WINDOW + 1);

  localparam logic [DELAY_WIDTH-1:0] MAXD_CODE = DELAY_WIDTH'(MAXD);
  localparam logic [DELAY_WIDTH-1:0] FILL_LAST = DELAY_WIDTH'(MAXD - 1);
  localparam logic [DELAY_WIDTH-1:0] D_ONE     = DELAY_WIDTH'(1);
  localparam logic [CNT_W-1:0]       WIN_LAST  = CNT_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0]       WIN_FULL  = CNT_W'(WINDOW);
  localparam logic [CNT_W-1:0]       C_ONE     = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FILL   = 3'd1,
    ST_SEARCH = 3'd2,
    ST_LOCKED = 3'd3,
    ST_FAIL   = 3'd4
  } state_t;

  state_t                  state_reg,  state_next;
  logic [DELAY_WIDTH-1:0]  delay_reg,  delay_next;
  logic [DELAY_WIDTH-1:0]  fill_reg,   fill_next;
  logic [CNT_W-1:0]        cnt_reg,    cnt_next;
  logic                    locked_reg, locked_next;
  logic                    fail_reg,   fail_next;
  logic                    busy_reg,   busy_next;

  // hist_reg[k] holds ref_in from k+1 qualified samples ago.
  logic [DATA_WIDTH-1:0] hist_reg [MAXD];
  // tap[d] is the reference value d samples ago; tap[0] is the live input.
  logic [DATA_WIDTH-1:0] tap [NTAPS];
  logic                  match;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAXD; i++) begin
        hist_reg[i] <= '0;
      end
    end else if (en) begin
      hist_reg[0] <= ref_in;
      for (int i = 1; i < MAXD; i++) begin
        hist_reg[i] <= hist_reg[i-1];
      end
    end
  end

  assign tap[0] = ref_in;
  generate
    for (genvar gi = 0; gi < MAXD; gi++) begin : g_tap
      assign tap[gi+1] = hist_reg[gi];
    end
  endgenerate

  // The candidate under test is always delay_reg, both while searching and
  // while locked, so one comparator serves every state.
  assign match = (dly_in == tap[delay_reg]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      delay_reg  <= '0;
      fill_reg   <= '0;
      cnt_reg    <= '0;
      locked_reg <= 1'b0;
      fail_reg   <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      delay_reg  <= delay_next;
      fill_reg   <= fill_next;
      cnt_reg    <= cnt_next;
      locked_reg <= locked_next;
      fail_reg   <= fail_next;
      busy_reg   <= busy_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    delay_next = delay_reg;
    fill_next  = fill_reg;
    cnt_next   = cnt_reg;

    if (en) begin
      if (start) begin
        // Restart wins over any lock or mismatch decided in this cycle.
        state_next = ST_FILL;
        delay_next = '0;
        fill_next  = '0;
        cnt_next   = '0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
          end
          ST_FILL: begin
            if (fill_reg == FILL_LAST) begin
              state_next = ST_SEARCH;
              fill_next  = '0;
              delay_next = '0;
              cnt_next   = '0;
            end else begin
              fill_next = fill_reg + D_ONE;
            end
          end
          ST_SEARCH: begin
            if (match) begin
              if (cnt_reg == WIN_LAST) begin
                state_next = ST_LOCKED;
                cnt_next   = WIN_FULL;
              end else begin
                cnt_next = cnt_reg + C_ONE;
              end
            end else begin
              cnt_next = '0;
              // The last candidate failing ends the search; delay stays at MAXD.
              if (delay_reg == MAXD_CODE) begin
                state_next = ST_FAIL;
              end else begin
                delay_next = delay_reg + D_ONE;
              end
            end
          end
          ST_LOCKED: begin
            // History is still valid, so a lost lock re-searches without refill.
            if (!match) begin
              state_next = ST_SEARCH;
              delay_next = '0;
              cnt_next   = '0;
            end
          end
          ST_FAIL: begin
          end
          default: begin
            state_next = ST_IDLE;
            delay_next = '0;
            fill_next  = '0;
            cnt_next   = '0;
          end
        endcase
      end
    end

    locked_next = (state_next == ST_LOCKED);
    fail_next   = (state_next == ST_FAIL);
    busy_next   = (state_next == ST_FILL) || (state_next == ST_SEARCH);
  end

  assign delay  = delay_reg;
  assign locked = locked_reg;
  assign fail   = fail_reg;
  assign busy   = busy_reg;

endmodule

// File: tb/tb_rt_delay_detect.sv
`timescale 1ns/1ps
// Testbench for rt_delay_detect: a driver issues one sample per clock and
// pushes the reference model's expected outputs into a queue; a monitor pops
// one entry after each clock edge and compares it with the DUT outputs.
module tb_rt_delay_detect;

  localparam int DW   = 8;
  localparam int LW   = 5;
  localparam int WIN  = 16;
  localparam int MAXD = 31;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic          en     = 1'b0;
  logic          start  = 1'b0;
  logic [DW-1:0] ref_in = '0;
  logic [DW-1:0] dly_in = '0;
  logic [LW-1:0] delay;
  logic          locked;
  logic          fail;
  logic          busy;

  rt_delay_detect #(
    .DATA_WIDTH (DW),
    .DELAY_WIDTH(LW),
    .WINDOW     (WIN)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .start (start),
    .ref_in(ref_in),
    .dly_in(dly_in),
    .delay (delay),
    .locked(locked),
    .fail  (fail),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          locked;
    logic          fail;
    logic          busy;
    logic [LW-1:0] delay;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    obs_t e;
    obs_t a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {locked, fail, busy, delay};
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL cycle_check @%0t: got locked=%0b fail=%0b busy=%0b delay=%0d, expected locked=%0b fail=%0b busy=%0b delay=%0d",
                   $time, a.locked, a.fail, a.busy, a.delay, e.locked, e.fail, e.busy, e.delay);
        end
      end
    end
  end

  // ---------------- reference model ----------------
  localparam int M_IDLE = 0, M_FILL = 1, M_SEARCH = 2, M_LOCKED = 3, M_FAIL = 4;
  int            m_mode;
  int            m_cand;
  int            m_run;
  int            m_fill_seen;
  logic [DW-1:0] m_past[$];   // m_past[k] = reference value k+1 samples ago

  function automatic void model_reset();
    m_mode      = M_IDLE;
    m_cand      = 0;
    m_run       = 0;
    m_fill_seen = 0;
    m_past.delete();
    for (int i = 0; i < MAXD; i++) m_past.push_back('0);
  endfunction

  function automatic void model_step(input logic en_v, input logic start_v,
                                     input logic [DW-1:0] r, input logic [DW-1:0] d);
    logic hit;
    if (en_v) begin
      hit = (m_cand == 0) ? (d == r) : (m_past[m_cand-1] == d);
      if (start_v) begin
        m_mode = M_FILL; m_fill_seen = 0; m_cand = 0; m_run = 0;
      end else if (m_mode == M_FILL) begin
        m_fill_seen++;
        if (m_fill_seen == MAXD) begin
          m_mode = M_SEARCH; m_cand = 0; m_run = 0;
        end
      end else if (m_mode == M_SEARCH) begin
        if (hit) begin
          m_run++;
          if (m_run == WIN) m_mode = M_LOCKED;
        end else begin
          m_run = 0;
          if (m_cand == MAXD) m_mode = M_FAIL;
          else m_cand++;
        end
      end else if (m_mode == M_LOCKED && !hit) begin
        m_mode = M_SEARCH; m_cand = 0; m_run = 0;
      end
      m_past.push_front(r);
      void'(m_past.pop_back());
    end
  endfunction

  function automatic obs_t model_out();
    return {m_mode == M_LOCKED, m_mode == M_FAIL,
            (m_mode == M_FILL) || (m_mode == M_SEARCH), LW'(m_cand)};
  endfunction

  // ---------------- stimulus source ----------------
  int            src_mode;    // 0: LFSR, 1: random, 2: constant 8'hAA
  int            src_delay;
  bit            src_inv;
  logic [6:0]    lfsr = 7'h01;
  logic [DW-1:0] src_q[$];    // src_q[k] = sample generated k samples ago

  // 7-bit maximal LFSR, zero-extended: no value repeats within 127 samples and
  // an inverted sample (MSB set) can never equal any reference sample.
  function automatic logic [DW-1:0] next_sample();
    logic [DW-1:0] v;
    case (src_mode)
      0: begin
        lfsr = lfsr[0] ? ((lfsr >> 1) ^ 7'h60) : (lfsr >> 1);
        v = {1'b0, lfsr};
      end
      1:       v = DW'($urandom);
      default: v = 8'hAA;
    endcase
    return v;
  endfunction

  logic last_busy   = 1'b0;
  logic last_locked = 1'b0;
  int   busy_seen   = 0;

  task automatic drive_cycle(input bit rst_v, input bit en_v, input bit start_v);
    logic [DW-1:0] r;
    logic [DW-1:0] base;
    @(posedge clk);
    #2;
    last_busy   = busy;
    last_locked = locked;
    if (busy) busy_seen++;
    rst_n = rst_v;
    if (!rst_v) begin
      en    = 1'b0;
      start = 1'b0;
      #1;
      check("async_reset_outputs", {locked, fail, busy, delay}, 0);
      model_reset();
    end else begin
      en    = en_v;
      start = start_v;
      if (en_v) begin
        r = next_sample();
        src_q.push_front(r);
        void'(src_q.pop_back());
        base   = (src_delay == 0) ? r : src_q[src_delay];
        ref_in = r;
        dly_in = src_inv ? ~base : base;
      end
      model_step(en_v, start_v, ref_in, dly_in);
    end
    exp_q.push_back(model_out());
  endtask

  task automatic run_until_idle(input int en_mode, input int budget, input string name);
    int n;
    bit en_v;
    n = 0;
    do begin
      case (en_mode)
        0:       en_v = 1'b1;
        1:       en_v = (n % 2) == 1;
        default: en_v = ($urandom_range(0, 3) != 0);
      endcase
      drive_cycle(1'b1, en_v, 1'b0);
      n++;
    end while (last_busy && n < budget);
    check({name, "_done_in_budget"}, int'(n < budget), 1);
  endtask

  task automatic scenario(input string name, input int mode, input int dly, input bit inv,
                          input int en_mode, input int exp_busy, input bit exp_lock,
                          input int exp_delay);
    src_mode  = mode;
    src_delay = dly;
    src_inv   = inv;
    drive_cycle(1'b1, 1'b1, 1'b1);
    busy_seen = 0;
    run_until_idle(en_mode, 400, name);
    if (exp_busy >= 0) check({name, "_busy_cycles"}, busy_seen, exp_busy);
    check({name, "_locked"}, locked, exp_lock);
    check({name, "_fail"}, fail, !exp_lock);
    check({name, "_delay"}, delay, exp_delay);
    $display("scenario %s: busy_cycles=%0d locked=%0b fail=%0b delay=%0d",
             name, busy_seen, locked, fail, delay);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    int d;
    bit inv;
    bit s;
    for (int i = 0; i < 64; i++) src_q.push_back('0);
    src_mode  = 0;
    src_delay = 3;
    src_inv   = 1'b0;
    model_reset();

    repeat (3) drive_cycle(1'b0, 1'b0, 1'b0);
    check("reset_state", {locked, fail, busy, delay}, 0);
    repeat (2) drive_cycle(1'b1, 1'b1, 1'b0);
    check("idle_without_start_busy", busy, 0);

    // Lock at delay 3: 31 fill + 3 mismatches + 16 matches.
    scenario("lock3", 0, 3, 1'b0, 0, 50, 1'b1, 3);
    repeat (8) drive_cycle(1'b1, 1'b1, 1'b0);
    check("lock3_stable", locked, 1);

    // Source delay changes to 5 while locked.
    src_delay = 5;
    n = 0;
    do begin
      drive_cycle(1'b1, 1'b1, 1'b0);
      n++;
    end while (last_locked && n < 10);
    check("switch_lock_drop_cycles", n, 2);
    n = 0;
    do begin
      drive_cycle(1'b1, 1'b1, 1'b0);
      n++;
    end while (!last_locked && n < 40);
    check("relock_cycles", n, 21);
    check("relock_delay", delay, 5);
    $display("scenario relock5: cycles_after_drop=%0d locked=%0b delay=%0d", n, locked, delay);

    // Start mid-SEARCH: the restart must refill from scratch.
    src_delay = 3;
    drive_cycle(1'b1, 1'b1, 1'b1);
    repeat (33) drive_cycle(1'b1, 1'b1, 1'b0);
    check("pre_restart_busy", busy, 1);
    scenario("restart", 0, 3, 1'b0, 0, 50, 1'b1, 3);

    // Reset mid-LOCKED: outputs clear without a clock edge, no residual lock.
    drive_cycle(1'b0, 1'b0, 1'b0);
    drive_cycle(1'b0, 1'b0, 1'b0);
    repeat (3) drive_cycle(1'b1, 1'b1, 1'b0);
    check("no_residual_lock", locked, 0);
    check("no_residual_busy", busy, 0);
    $display("scenario reset_mid_locked: locked=%0b busy=%0b delay=%0d", locked, busy, delay);

    // No candidate matches: 31 fill + 32 mismatches.
    scenario("nomatch", 0, 3, 1'b1, 0, 63, 1'b0, 31);
    repeat (5) drive_cycle(1'b1, 1'b1, 1'b0);
    check("fail_holds", fail, 1);

    // en toggling; streams advance only on qualified cycles.
    scenario("en_gate", 0, 3, 1'b0, 1, -1, 1'b1, 3);
    drive_cycle(1'b1, 1'b0, 1'b1);
    drive_cycle(1'b1, 1'b1, 1'b0);
    check("start_without_en_ignored", locked, 1);

    // Constant data locks at delay 0 whatever the true delay.
    scenario("const_aa", 2, 7, 1'b0, 0, 47, 1'b1, 0);

    // Random data, delays, en gating, occasional restarts and delay changes.
    for (int t = 0; t < 6; t++) begin
      d   = $urandom_range(0, MAXD);
      inv = ($urandom_range(0, 3) == 0);
      src_mode  = 1;
      src_delay = d;
      src_inv   = inv;
      drive_cycle(1'b1, 1'b1, 1'b1);
      for (int c = 0; c < 200; c++) begin
        s = ($urandom_range(0, 299) == 0);
        if ($urandom_range(0, 149) == 0) src_delay = $urandom_range(0, MAXD);
        drive_cycle(1'b1, $urandom_range(0, 3) != 0, s);
      end
      $display("random run %0d: src_delay=%0d inv=%0b -> locked=%0b fail=%0b busy=%0b delay=%0d",
               t, src_delay, inv, locked, fail, busy, delay);
    end

    repeat (3) @(posedge clk);
    #5;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
